// File: rtl/fp_align.sv
// Pre-adder alignment for binary32 addition: unpack, order by magnitude, and
// iteratively right-shift the smaller mantissa with sticky accumulation.
//
// state  | meaning
// IDLE   | waiting for an operand pair; in_ready high
// SHIFT  | shifting mant_small down by up to SHIFT_STEP bits per cycle
// DONE   | result presented; held until out_ready
module fp_align #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] mant_large,
  output logic [23:0] mant_small,
  output logic        sticky,
  output logic [7:0]  exp_large,
  output logic        sign_large,
  output logic        eff_sub,
  output logic        swapped,
  output logic        special
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [4:0] L_STEP  = 5'(SHIFT_STEP);

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [23:0] r_mant_large;
  logic [23:0] r_mant_small;
  logic        r_sticky;
  logic [7:0]  r_exp_large;
  logic        r_sign_large;
  logic        r_eff_sub;
  logic        r_swapped;
  logic        r_special;

  logic [7:0]  w_exp_a;
  logic [7:0]  w_exp_b;
  logic [7:0]  w_e_a;
  logic [7:0]  w_e_b;
  logic [23:0] w_mant_a;
  logic [23:0] w_mant_b;
  logic        w_b_larger;
  logic [7:0]  w_diff;
  logic        w_special;
  logic [4:0]  w_cnt;
  logic [4:0]  w_k;
  logic [23:0] w_mask;
  logic        w_lost;

  // Denormals and zero use effective exponent 1 with no hidden bit.
  assign w_exp_a  = op_a[30:23];
  assign w_exp_b  = op_b[30:23];
  assign w_e_a    = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
  assign w_e_b    = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
  assign w_mant_a = {(w_exp_a != 8'd0), op_a[22:0]};
  assign w_mant_b = {(w_exp_b != 8'd0), op_b[22:0]};

  assign w_b_larger = (w_e_b > w_e_a) || ((w_e_b == w_e_a) && (w_mant_b > w_mant_a));
  assign w_diff     = w_b_larger ? (w_e_b - w_e_a) : (w_e_a - w_e_b);
  assign w_special  = (w_exp_a == 8'hFF) || (w_exp_b == 8'hFF);
  assign w_cnt      = w_special ? 5'd0 : ((w_diff > 8'd24) ? 5'd24 : w_diff[4:0]);

  assign w_k    = (r_cnt < L_STEP) ? r_cnt : L_STEP;
  assign w_mask = ~(24'hFFFFFF << w_k);
  assign w_lost = |(r_mant_small & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 5'd0;
      r_mant_large <= 24'd0;
      r_mant_small <= 24'd0;
      r_sticky     <= 1'b0;
      r_exp_large  <= 8'd0;
      r_sign_large <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_swapped    <= 1'b0;
      r_special    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt        <= w_cnt;
            r_mant_large <= w_b_larger ? w_mant_b : w_mant_a;
            r_mant_small <= w_b_larger ? w_mant_a : w_mant_b;
            r_sticky     <= 1'b0;
            r_exp_large  <= w_special ? 8'hFF : (w_b_larger ? w_e_b : w_e_a);
            r_sign_large <= w_b_larger ? op_b[31] : op_a[31];
            r_eff_sub    <= op_a[31] ^ op_b[31];
            r_swapped    <= w_b_larger;
            r_special    <= w_special;
            r_state      <= (w_cnt != 5'd0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_mant_small <= r_mant_small >> w_k;
          r_sticky     <= r_sticky | w_lost;
          r_cnt        <= r_cnt - w_k;
          if (r_cnt == w_k) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign mant_large = r_mant_large;
  assign mant_small = r_mant_small;
  assign sticky     = r_sticky;
  assign exp_large  = r_exp_large;
  assign sign_large = r_sign_large;
  assign eff_sub    = r_eff_sub;
  assign swapped    = r_swapped;
  assign special    = r_special;

endmodule

// File: doc/fp_align.md
# fp_align

Pre-adder alignment stage of the single-precision floating-point adder, feeding the adder core and the post-add normaliser. It unpacks two IEEE-754 binary32 operands and orders them by magnitude. It right-shifts the smaller mantissa by the exponent difference, using an iterative shifter that moves SHIFT_STEP bits per cycle, and accumulates a sticky bit. Results are presented with the larger exponent through a valid/ready handshake.

## Interface
- SHIFT_STEP, 4, bits shifted per SHIFT cycle; legal 1..24
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept; high only in IDLE
- op_a  in  32  binary32 operand A
- op_b  in  32  binary32 operand B
- out_valid  out  1  aligned result valid; high only in DONE
- out_ready  in  1  downstream accepts result
- mant_large  out  24  larger-magnitude mantissa including hidden bit
- mant_small  out  24  smaller mantissa, right-shifted to exp_large
- sticky  out  1  OR of all bits shifted out of mant_small
- exp_large  out  8  effective exponent of the larger operand
- sign_large  out  1  sign of the larger operand
- eff_sub  out  1  sign_a XOR sign_b
- swapped  out  1  1 if B is the larger operand
- special  out  1  either operand has exponent 0xFF (Inf/NaN)

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- **Accept** happens on the edge where in_valid && in_ready.
- **Unpack** each operand: hidden = (exp != 0). Effective exponent e = (exp == 0) ? 1 : exp. mant = {hidden, frac}.
- **Ordering**: the larger operand has the greater e. If e is equal, the greater mant is larger. On a full tie, A is larger and swapped = 0.
- Shift count: cnt = min(e_large - e_small, 24), held in a 5-bit register.
- **special**: if either exponent is 0xFF, then special = 1, exp_large = 0xFF, and cnt is forced to 0. The remaining outputs are computed normally, with mant_small unshifted.
- **On accept**: load all output registers with sticky = 0.
  - Next state is SHIFT if cnt > 0, else DONE.
- **SHIFT**: each cycle, k = min(cnt, SHIFT_STEP).
  - mant_small <= mant_small >> k.
  - sticky <= sticky | (OR of the k bits shifted out).
  - cnt <= cnt - k.
  - When cnt - k == 0, next state is DONE.
- **DONE**: out_valid = 1, and all outputs are held stable. On out_valid && out_ready, the next state is IDLE.
- in_valid is ignored outside IDLE. There is no overlap between transactions.
- Width rules:
  - An exponent difference of up to 253 saturates to 24, which fully clears mant_small.
  - Sticky covers all discarded bits.
  - exp_large is never modified here; the normaliser adjusts it.

## Timing
- **Reset values**:
  - Asserting rst_n low asynchronously forces state to IDLE, out_valid = 0, and every data output to 0.
  - in_ready = 1 once state is IDLE.
  - An in-flight transaction is dropped without output.
- **Latency** from accept edge to out_valid high is 1 + ceil(cnt / SHIFT_STEP) cycles:
  - cnt = 0 or special: 1 cycle.
- in_ready falls in the cycle after accept and rises the cycle after the DONE handshake.
- Minimum accept-to-accept interval: latency + 1 cycle (the DONE handshake cycle plus the return to IDLE).
- out_ready held low: DONE persists indefinitely, outputs do not change, in_ready stays 0.
- out_ready already high when DONE is entered: handshake completes in that first DONE cycle.

## Test plan
- **Equal operands**: op_a = op_b = 0x3F800000 -> one cycle after accept: out_valid = 1, mant_large = mant_small = 0x800000, exp_large = 0x7F, sticky = 0, swapped = 0, eff_sub = 0.
- **B larger, diff 1**: op_a = 0x3F800000, op_b = 0x40400000, SHIFT_STEP = 4 -> latency 2, exp_large = 0x80, mant_large = 0xC00000, mant_small = 0x400000, swapped = 1, sticky = 0.
- **Full shift-out**: op_a = 0x4B800000, op_b = 0x3F800001 -> cnt = 24, latency 7 (six SHIFT cycles), mant_small = 0, sticky = 1, exp_large = 0x97.
- **Special**: op_a = 0x3F800000, op_b = 0x7F800000 -> special = 1, exp_large = 0xFF, latency 1, no SHIFT state entered.
- **Effective subtract**: op_a = 0xBF800000, op_b = 0x3F000000 -> eff_sub = 1, sign_large = 1, swapped = 0, mant_small = 0x400000, latency 2.
- **Backpressure and reset**:
  - Hold out_ready = 0 for 5 cycles in DONE with in_valid pulsed -> outputs stable, in_ready = 0, no new accept.
  - Then drop rst_n during a SHIFT -> out_valid = 0 immediately; after release, in_ready = 1 and the next transaction completes normally.
